hazard_scoreboard: RTL

- Parametrised hazard-detection and operand-forwarding unit for the in-order MIPS pipeline.
- Sits beside the ID stage.
- Tracks in-flight register writes across DEPTH post-ID stages in a shift-register scoreboard.
- Generates a stall (bubble) request and per-operand forwarding selects and data for ID-stage operands, including ID-resolved branches.
- Generalises the fixed EX/MEM forwarding and load-use bubble logic to any depth and any load-result stage.

---
 rtl/hazard_scoreboard.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard detection and operand forwarding for the in-order pipeline, placed
//   beside the ID stage. A shift-register scoreboard follows in-flight
//   register writes through DEPTH post-ID stages (1 = EX, 2 = MEM, ...).
//   For each ID source operand the youngest matching in-flight write is
//   either forwarded from its stage result or, if not yet available, turned
//   into a stall (bubble) request. ID-resolved branches need results one
//   stage earlier than ALU consumers.
//
// Parameters
//   AW, DW       register address / datapath width
//   DEPTH        tracked post-ID stages
//   LOAD_STAGE   stage whose output carries load data (1..DEPTH)
//   SW           forwarding-select width (derived)
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   id_valid, id_rs, id_rt    ID instruction and its source registers
//   id_rs_used, id_rt_used    sources actually read
//   id_rd, id_regw            destination and write enable
//   id_is_load, id_branch     load / compares-in-ID flags
//   flush                     squash the ID instruction
//   id_rf_a, id_rf_b          register-file read data
//   stage_data                stage k result at [k*DW-1:(k-1)*DW]
//   stall                     hold PC and IF/ID, bubble into stage 1
//   fwd_sel_a, fwd_sel_b      0 = register file, k = stage k
//   op_a, op_b                resolved operands
//   perf_stall_cnt, perf_fwd_cnt   saturating counters (optional)
//
// Optional feature macro: HAZARD_SCOREBOARD_PERF_EN adds the perf counters.

module hazard_scoreboard #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  localparam int SW        = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [AW-1:0]       id_rs,
  input  logic [AW-1:0]       id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic [AW-1:0]       id_rd,
  input  logic                id_regw,
  input  logic                id_is_load,
  input  logic                id_branch,
  input  logic                flush,
  input  logic [DW-1:0]       id_rf_a,
  input  logic [DW-1:0]       id_rf_b,
  input  logic [DEPTH*DW-1:0] stage_data,
  output logic                stall,
  output logic [SW-1:0]       fwd_sel_a,
  output logic [SW-1:0]       fwd_sel_b,
  output logic [DW-1:0]       op_a,
  output logic [DW-1:0]       op_b
`ifdef HAZARD_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_fwd_cnt
`endif
);

  // One extra bit so that rdy + branch (up to DEPTH+1) fits.
  localparam int NW = SW + 1;

  if (LOAD_STAGE < 1 || LOAD_STAGE > DEPTH) begin : g_bad_load_stage
    $error("hazard_scoreboard: LOAD_STAGE must be in 1..DEPTH");
  end

  typedef struct packed {
    logic          hit;
    logic [SW-1:0] stage;
    logic [NW-1:0] rdy;
  } match_t;

  logic [DEPTH:1] e_v;
  logic [AW-1:0]  e_rd  [1:DEPTH];
  logic [NW-1:0]  e_rdy [1:DEPTH];

  logic   issue;
  match_t m_a, m_b;
  logic   haz_a, haz_b;

  // ---------------------------------------------------------------------------
  // Scoreboard shift register
  // ---------------------------------------------------------------------------
  assign issue = id_valid && id_regw && (id_rd != '0) && !stall && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_v <= '0;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        e_rd[k]  <= '0;
        e_rdy[k] <= '0;
      end
    end else begin
      e_v[1]   <= issue;
      e_rd[1]  <= id_rd;
      e_rdy[1] <= id_is_load ? NW'(LOAD_STAGE) : NW'(1);
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        e_v[k]   <= e_v[k-1];
        e_rd[k]  <= e_rd[k-1];
        e_rdy[k] <= e_rdy[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Match search: first hit scanning from stage 1 is the youngest writer
  // ---------------------------------------------------------------------------
  function automatic match_t find_match(input logic [AW-1:0] src);
    match_t m;
    m = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (!m.hit && src != '0 && e_v[k] && e_rd[k] == src) begin
        m.hit   = 1'b1;
        m.stage = SW'(k);
        m.rdy   = e_rdy[k];
      end
    end
    return m;
  endfunction

  always_comb begin
    logic [NW-1:0] need_a, need_b;
    logic          ok_a, ok_b;
    m_a    = find_match(id_rs);
    m_b    = find_match(id_rt);
    need_a = m_a.rdy + NW'(id_branch);
    need_b = m_b.rdy + NW'(id_branch);
    ok_a   = m_a.hit && (NW'(m_a.stage) >= need_a);
    ok_b   = m_b.hit && (NW'(m_b.stage) >= need_b);
    // Not-yet-ready sources stall; select stays on the register file then.
    haz_a     = id_rs_used && m_a.hit && !ok_a;
    haz_b     = id_rt_used && m_b.hit && !ok_b;
    fwd_sel_a = ok_a ? m_a.stage : '0;
    fwd_sel_b = ok_b ? m_b.stage : '0;
  end

  assign stall = id_valid && !flush && (haz_a || haz_b);

  // ---------------------------------------------------------------------------
  // Operand muxes
  // ---------------------------------------------------------------------------
  always_comb begin
    op_a = id_rf_a;
    op_b = id_rf_b;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (fwd_sel_a == SW'(k)) op_a = stage_data[(k-1)*DW +: DW];
      if (fwd_sel_b == SW'(k)) op_b = stage_data[(k-1)*DW +: DW];
    end
  end

`ifdef HAZARD_SCOREBOARD_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic fwd_event;
  assign fwd_event = id_valid && !stall && (fwd_sel_a != '0 || fwd_sel_b != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (stall && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (fwd_event && perf_fwd_cnt != '1)
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
    end
  end
`endif

endmodule
